// File: rtl/reset_release_sequencer.sv
// Staged reset controller: waits for PLL lock and init done, then releases NUM_STAGES
// active-low resets in order. Define LOCK_DEBOUNCE_EN to build the lock-qualification state.
module reset_release_sequencer #(
    parameter int unsigned NUM_STAGES         = 4,
    parameter int unsigned STAGE_DLY          = 1024,
    parameter int unsigned LOCK_STABLE_CYCLES = 256
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    input  logic                  i_pll_lock,
    input  logic                  i_init_done,
    input  logic                  i_sw_rst_req,
    output logic                  o_sw_rst_ack,
    output logic [NUM_STAGES-1:0] o_stage_resetn,
    output logic                  o_seq_done,
    output logic [7:0]            o_lock_loss_cnt,
    output logic [2:0]            o_seq_state
);

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_QUAL    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam logic [15:0] DLY_LAST = 16'(STAGE_DLY - 1);

`ifdef LOCK_DEBOUNCE_EN
    localparam int unsigned QW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_STABLE_CYCLES - 1);
    logic [QW-1:0] r_qual_cnt;
`else
    // QUAL is not built; the parameter is kept so both builds share one interface
    localparam int unsigned lock_stable_unused = LOCK_STABLE_CYCLES;
`endif

    logic                  r_lock_m, r_lock_s;
    logic                  r_init_m, r_init_s, r_init_seen;
    logic                  r_req_m, r_req_s, r_req_d;
    state_t                r_state;
    logic [15:0]           r_cnt;
    logic [NUM_STAGES-1:0] r_stage;
    logic                  r_done;
    logic                  r_ack;
    logic [7:0]            r_llc;

    logic                  w_req_rise;
    logic                  w_init_ok;
    logic [NUM_STAGES-1:0] w_stage_next;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_lock_m    <= 1'b0;
            r_lock_s    <= 1'b0;
            r_init_m    <= 1'b0;
            r_init_s    <= 1'b0;
            r_init_seen <= 1'b0;
            r_req_m     <= 1'b0;
            r_req_s     <= 1'b0;
            r_req_d     <= 1'b0;
        end else begin
            r_lock_m    <= i_pll_lock;
            r_lock_s    <= r_lock_m;
            r_init_m    <= i_init_done;
            r_init_s    <= r_init_m;
            r_init_seen <= r_init_seen | r_init_s;
            r_req_m     <= i_sw_rst_req;
            r_req_s     <= r_req_m;
            r_req_d     <= r_req_s;
        end
    end

    assign w_req_rise   = r_req_s & ~r_req_d;
    assign w_init_ok    = r_init_s | r_init_seen;
    // Thermometer step: next stage bit joins the already-released ones
    assign w_stage_next = r_stage | (r_stage << 1) | NUM_STAGES'(1);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
            r_stage <= '0;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_llc   <= '0;
`ifdef LOCK_DEBOUNCE_EN
            r_qual_cnt <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_WAIT: begin
                    r_stage <= '0;
                    r_done  <= 1'b0;
                    if (w_req_rise) r_ack <= 1'b1;
                    if (r_lock_s && w_init_ok) begin
                        r_cnt <= '0;
`ifdef LOCK_DEBOUNCE_EN
                        r_qual_cnt <= '0;
                        r_state    <= S_QUAL;
`else
                        r_state <= S_RELEASE;
`endif
                    end
                end
`ifdef LOCK_DEBOUNCE_EN
                S_QUAL: begin
                    if (w_req_rise) r_ack <= 1'b1;
                    if (!r_lock_s) begin
                        r_state    <= S_WAIT;
                        r_qual_cnt <= '0;
                    end else if (r_qual_cnt == QUAL_LAST) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                    end else begin
                        r_qual_cnt <= r_qual_cnt + QW'(1);
                    end
                end
`endif
                S_RELEASE, S_RUN: begin
                    // Lock loss outranks a simultaneous request; the ACK still reports the reset
                    if (!r_lock_s) begin
                        r_state <= S_WAIT;
                        r_stage <= '0;
                        r_done  <= 1'b0;
                        if (r_llc != 8'hFF) r_llc <= r_llc + 8'd1;
                        if (w_req_rise) r_ack <= 1'b1;
                    end else if (w_req_rise) begin
                        r_state <= S_HOLD;
                        r_stage <= '0;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_state == S_RELEASE) begin
                        if (r_cnt == DLY_LAST) begin
                            r_cnt   <= '0;
                            r_stage <= w_stage_next;
                            if (&w_stage_next) begin
                                r_state <= S_RUN;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end
                end
                S_HOLD: begin
                    r_stage <= '0;
                    r_done  <= 1'b0;
                    if (!r_lock_s) begin
                        r_state <= S_WAIT;
                        r_ack   <= 1'b1;
                        if (r_llc != 8'hFF) r_llc <= r_llc + 8'd1;
                    end else if (r_cnt == DLY_LAST) begin
                        r_state <= S_WAIT;
                        r_ack   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_stage <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sw_rst_ack    = r_ack;
    assign o_stage_resetn  = r_stage;
    assign o_seq_done      = r_done;
    assign o_lock_loss_cnt = r_llc;
    assign o_seq_state     = r_state;

endmodule
